imm_alloc: RTL and testbench
============================

# imm_alloc

Allocator for the immediate buffer's entries. At dispatch it hands out up to two free entry pointers per cycle (`imm_ptr_1`, `imm_ptr_2`). At issue it reclaims the entries named by the issue stage. It sits beside the immediate buffer: it drives that buffer's dispatch-side pointers and `invalid` strobes, and consumes the same issue-side pointers the buffer reads with.

## Interface
Parameters:
- `IB_ENT_NUM`, 16: number of immediate-buffer entries.
- `IB_ENT_SEL`, 4: pointer width, equal to log2(`IB_ENT_NUM`).
- `SPECTAG_LEN`, 5: width of the one-hot speculative-tag masks.

Ports. Clock and reset: reset reset, synchronous, active-high; clock clk.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `req_1`, `req_2`  in  1  dispatch slot 1/2 carries an immediate.
- `stall`  in  1  dispatch is held by another structure.
- `spectag_1`, `spectag_2`  in  `SPECTAG_LEN`  branch-dependency mask of slot 1/2.
- `issued_1`, `issued_2`  in  1  issue port 1/2 consumed an immediate.
- `issue_imm_ptr_1`, `issue_imm_ptr_2`  in  `IB_ENT_SEL`  entries released by issue.
- `prmiss`  in  1  branch mispredict.
- `prsuccess`  in  1  branch resolved correct.
- `prtag`  in  `SPECTAG_LEN`  one-hot tag of the resolving branch.
- `allocatable`  out  1  enough free entries for this cycle's requests.
- `imm_ptr_1`, `imm_ptr_2`  out  `IB_ENT_SEL`  lowest and second-lowest free index.
- `invalid1`, `invalid2`  out  1  low when slot 1/2 actually allocates this cycle.
- `free_cnt`  out  `IB_ENT_SEL`+1  number of free entries.

## Operation
State:
- `busy[IB_ENT_NUM]`: allocation bitmap.
- `tag[IB_ENT_NUM]`: per-entry spectag mask, `SPECTAG_LEN` bits each.

Pointer selection and allocation:
- `imm_ptr_1` is the lowest index with `busy`=0. `imm_ptr_2` is the next higher free index.
- Both pointers are combinational from registered `busy`, so they are always distinct when at least 2 entries are free.
- Each slot owns its own pointer. `req_2` alone still takes `imm_ptr_2`.
- `allocatable` = `free_cnt` ≥ `req_1`+`req_2`.
- `go` = `~stall & allocatable & ~prmiss`.
- `invalid1` = `~(req_1 & go)`; `invalid2` = `~(req_2 & go)`.
- An allocating slot sets `busy[ptr]`=1 and `tag[ptr]`=`spectag_n`.

Release:
- `issued_n` clears `busy[issue_imm_ptr_n]`. This applies in every cycle, including `stall` and `prmiss` cycles.
- Released entries become allocatable the next cycle.
- Same-cycle release and allocation of one index cannot happen, because allocation only picks entries that are currently free.
- Releasing an entry that is already free, or both issue ports naming the same index, is illegal. The bench asserts on it; RTL behaviour is don't-care.

Counter:
- `free_cnt` is a popcount of ~`busy`.
- Reset values: `busy`=0, `tag`=0, `free_cnt`=`IB_ENT_NUM`, `allocatable`=1, `imm_ptr_1`=0, `imm_ptr_2`=1.

Boundary cases:
- Full (`free_cnt`=0): `allocatable`=0 whenever any request is present. Pointers hold the value `IB_ENT_NUM`-1 and are not used.
- `free_cnt`=1 with both requests: the whole group stalls. There is no partial dispatch.
- Wrap: none. The search is positional, not circular.

## Timing
- Allocation and release take effect at the next rising edge. Pointers and `allocatable` update in the same cycle.
- Allocate→free→reallocate minimum loop is 2 cycles: the entry allocates at edge N, an issue at cycle N+k frees it at edge N+k+1, and it is re-offered from cycle N+k+1.
- Reset has priority over all other inputs and clears the allocator mid-operation.

## Configuration
`IMM_ALLOC_RECOVERY_EN`, when defined:
- `prmiss` frees every entry with `tag & prtag` ≠ 0 at the next edge.
- `prsuccess` clears the `prtag` bit from all `tag` masks.
- Issue releases in the same cycle still apply.

When not defined:
- `tag` storage is removed and `prsuccess`/`prtag` are ignored.
- `prmiss` only suppresses allocation for that cycle; no entries are freed.

## Structure
- `IB_ENT_NUM`, `IB_ENT_SEL` and `SPECTAG_LEN` belong in the shared constants header. Parameters default from them.
- One sub-module, `imm_alloc_search`: a two-result lowest-free priority encoder (first and second zero of `busy`) plus the popcount.

## Test plan
- After reset with `req_1`=`req_2`=1 for 8 cycles: pointers are (0,1), (2,3) … (14,15), then `allocatable`=0 with `free_cnt`=0.
- All busy; `issued_1` with `issue_imm_ptr_1`=5: the next cycle gives `imm_ptr_1`=5, `free_cnt`=1. `req_1`+`req_2` keeps `allocatable`=0; `req_1` alone allocates 5.
- `stall`=1 with requests: `invalid1`=`invalid2`=1 and the bitmap is unchanged, while a concurrent `issued_2` (ptr 3) still frees entry 3.
- Recovery on: allocate entries 0–3 with `spectag` 00010 and 4–5 with 00001, then `prmiss` with `prtag`=00010 → `free_cnt`=14 and `imm_ptr_1`=0.
- Recovery on: `prsuccess` with `prtag`=00010, then `prmiss` with `prtag`=00010 → nothing freed.
- Recovery off: the same `prmiss` frees nothing, and allocation is blocked only during the `prmiss` cycle.

Source files
------------

// File: rtl/imm_alloc_pkg.sv
// Shared constants for the immediate-buffer allocator.
package imm_alloc_pkg;
  localparam int unsigned IMM_IB_ENT_NUM  = 16;
  localparam int unsigned IMM_IB_ENT_SEL  = 4;
  localparam int unsigned IMM_SPECTAG_LEN = 5;
endpackage

// File: rtl/imm_alloc_search.sv
// Finds the first and second free entries of the busy bitmap and counts free entries.
module imm_alloc_search
  import imm_alloc_pkg::*;
#(
  parameter int unsigned IB_ENT_NUM = IMM_IB_ENT_NUM,
  parameter int unsigned IB_ENT_SEL = IMM_IB_ENT_SEL
) (
  input  logic [IB_ENT_NUM-1:0] busy,
  output logic [IB_ENT_SEL-1:0] first_free,
  output logic [IB_ENT_SEL-1:0] second_free,
  output logic [IB_ENT_SEL:0]   free_cnt
);
  localparam int unsigned CW = IB_ENT_SEL + 1;

  logic found_1;
  logic found_2;

  // Positional scan from index 0; a missing result parks on the top index.
  always_comb begin
    first_free  = IB_ENT_SEL'(IB_ENT_NUM - 1);
    second_free = IB_ENT_SEL'(IB_ENT_NUM - 1);
    free_cnt    = '0;
    found_1     = 1'b0;
    found_2     = 1'b0;
    for (int i = 0; i < int'(IB_ENT_NUM); i++) begin
      if (!busy[i]) begin
        free_cnt = free_cnt + CW'(1);
        if (!found_1) begin
          first_free = IB_ENT_SEL'(i);
          found_1    = 1'b1;
        end else if (!found_2) begin
          second_free = IB_ENT_SEL'(i);
          found_2     = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/imm_alloc.sv
// Immediate-buffer entry allocator: two pointers per cycle at dispatch, release at issue.
// Define IMM_ALLOC_RECOVERY_EN to enable speculative-tag based flush on mispredict.
module imm_alloc
  import imm_alloc_pkg::*;
#(
  parameter int unsigned IB_ENT_NUM  = IMM_IB_ENT_NUM,
  parameter int unsigned IB_ENT_SEL  = IMM_IB_ENT_SEL,
  parameter int unsigned SPECTAG_LEN = IMM_SPECTAG_LEN
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_1,
  input  logic                   req_2,
  input  logic                   stall,
  input  logic [SPECTAG_LEN-1:0] spectag_1,
  input  logic [SPECTAG_LEN-1:0] spectag_2,
  input  logic                   issued_1,
  input  logic                   issued_2,
  input  logic [IB_ENT_SEL-1:0]  issue_imm_ptr_1,
  input  logic [IB_ENT_SEL-1:0]  issue_imm_ptr_2,
  input  logic                   prmiss,
  input  logic                   prsuccess,
  input  logic [SPECTAG_LEN-1:0] prtag,
  output logic                   allocatable,
  output logic [IB_ENT_SEL-1:0]  imm_ptr_1,
  output logic [IB_ENT_SEL-1:0]  imm_ptr_2,
  output logic                   invalid1,
  output logic                   invalid2,
  output logic [IB_ENT_SEL:0]    free_cnt
);
  localparam int unsigned CW = IB_ENT_SEL + 1;

  logic [IB_ENT_NUM-1:0] busy;
  logic [IB_ENT_NUM-1:0] busy_nxt;
  logic                  go;

  imm_alloc_search #(
    .IB_ENT_NUM (IB_ENT_NUM),
    .IB_ENT_SEL (IB_ENT_SEL)
  ) u_search (
    .busy        (busy),
    .first_free  (imm_ptr_1),
    .second_free (imm_ptr_2),
    .free_cnt    (free_cnt)
  );

  // Dispatch is all-or-nothing for the request group.
  always_comb begin
    allocatable = free_cnt >= (CW'(req_1) + CW'(req_2));
    go          = ~stall & allocatable & ~prmiss;
    invalid1    = ~(req_1 & go);
    invalid2    = ~(req_2 & go);
  end

`ifdef IMM_ALLOC_RECOVERY_EN
  logic [SPECTAG_LEN-1:0] tag     [IB_ENT_NUM];
  logic [SPECTAG_LEN-1:0] tag_nxt [IB_ENT_NUM];

  // Resolved branches drop out of every dependency mask; new entries take the slot's mask.
  always_comb begin
    for (int i = 0; i < int'(IB_ENT_NUM); i++) begin
      tag_nxt[i] = prsuccess ? (tag[i] & ~prtag) : tag[i];
    end
    if (!invalid1) tag_nxt[imm_ptr_1] = spectag_1;
    if (!invalid2) tag_nxt[imm_ptr_2] = spectag_2;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(IB_ENT_NUM); i++) begin
      tag[i] <= reset ? '0 : tag_nxt[i];
    end
  end
`else
  logic unused_recovery;
  assign unused_recovery = ^{prsuccess, prtag, spectag_1, spectag_2};
`endif

  // Flush and issue release first; allocation only targets entries already free.
  always_comb begin
    busy_nxt = busy;
`ifdef IMM_ALLOC_RECOVERY_EN
    if (prmiss) begin
      for (int i = 0; i < int'(IB_ENT_NUM); i++) begin
        if (|(tag[i] & prtag)) busy_nxt[i] = 1'b0;
      end
    end
`endif
    if (issued_1) busy_nxt[issue_imm_ptr_1] = 1'b0;
    if (issued_2) busy_nxt[issue_imm_ptr_2] = 1'b0;
    if (!invalid1) busy_nxt[imm_ptr_1] = 1'b1;
    if (!invalid2) busy_nxt[imm_ptr_2] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end
endmodule

// File: tb/tb_imm_alloc.sv
// Directed self-checking bench for imm_alloc (both IMM_ALLOC_RECOVERY_EN builds).
module tb_imm_alloc;
  logic       clk;
  logic       reset;
  logic       req_1, req_2, stall;
  logic [4:0] spectag_1, spectag_2;
  logic       issued_1, issued_2;
  logic [3:0] issue_imm_ptr_1, issue_imm_ptr_2;
  logic       prmiss, prsuccess;
  logic [4:0] prtag;
  logic       allocatable;
  logic [3:0] imm_ptr_1, imm_ptr_2;
  logic       invalid1, invalid2;
  logic [4:0] free_cnt;

  int checks   = 0;
  int failures = 0;

  imm_alloc dut (
    .clk             (clk),
    .reset           (reset),
    .req_1           (req_1),
    .req_2           (req_2),
    .stall           (stall),
    .spectag_1       (spectag_1),
    .spectag_2       (spectag_2),
    .issued_1        (issued_1),
    .issued_2        (issued_2),
    .issue_imm_ptr_1 (issue_imm_ptr_1),
    .issue_imm_ptr_2 (issue_imm_ptr_2),
    .prmiss          (prmiss),
    .prsuccess       (prsuccess),
    .prtag           (prtag),
    .allocatable     (allocatable),
    .imm_ptr_1       (imm_ptr_1),
    .imm_ptr_2       (imm_ptr_2),
    .invalid1        (invalid1),
    .invalid2        (invalid2),
    .free_cnt        (free_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Illegal: both issue ports releasing the same entry.
  always @(posedge clk) begin
    if (!reset && issued_1 && issued_2 && issue_imm_ptr_1 == issue_imm_ptr_2)
      $error("illegal double release of entry %0d", issue_imm_ptr_1);
  end

  // Advance one cycle; inputs are then driven 1 time unit after the falling edge.
  task automatic next();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    req_1 = 0; req_2 = 0; stall = 0; issued_1 = 0; issued_2 = 0;
    issue_imm_ptr_1 = 0; issue_imm_ptr_2 = 0; prmiss = 0; prsuccess = 0;
    prtag = 0; spectag_1 = 0; spectag_2 = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    next();
    next();
    reset = 0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (free_cnt !== 5'd16) begin failures++; $display("FAIL reset_free_cnt got=%0d exp=16", free_cnt); end
    checks++; if (allocatable !== 1'b1) begin failures++; $display("FAIL reset_allocatable got=%0b exp=1", allocatable); end
    checks++; if (imm_ptr_1 !== 4'd0 || imm_ptr_2 !== 4'd1) begin failures++; $display("FAIL reset_ptrs got=(%0d,%0d) exp=(0,1)", imm_ptr_1, imm_ptr_2); end
    checks++; if (invalid1 !== 1'b1 || invalid2 !== 1'b1) begin failures++; $display("FAIL reset_invalid got=(%0b,%0b) exp=(1,1)", invalid1, invalid2); end
  endtask

  // Both slots request every cycle until the buffer is full.
  task automatic test_fill();
    for (int k = 0; k < 8; k++) begin
      req_1 = 1; req_2 = 1;
      #1;
      checks++;
      if (imm_ptr_1 !== 4'(2*k) || imm_ptr_2 !== 4'(2*k+1) || free_cnt !== 5'(16-2*k) || invalid1 !== 1'b0 || invalid2 !== 1'b0) begin
        failures++;
        $display("FAIL fill_step k=%0d got ptr=(%0d,%0d) cnt=%0d inv=(%0b,%0b) exp ptr=(%0d,%0d) cnt=%0d inv=(0,0)",
                 k, imm_ptr_1, imm_ptr_2, free_cnt, invalid1, invalid2, 2*k, 2*k+1, 16-2*k);
      end
      next();
    end
    #1;
    checks++; if (allocatable !== 1'b0 || free_cnt !== 5'd0) begin failures++; $display("FAIL fill_full got alloc=%0b cnt=%0d exp alloc=0 cnt=0", allocatable, free_cnt); end
    checks++; if (invalid1 !== 1'b1 || invalid2 !== 1'b1) begin failures++; $display("FAIL fill_full_invalid got=(%0b,%0b) exp=(1,1)", invalid1, invalid2); end
    checks++; if (imm_ptr_1 !== 4'd15 || imm_ptr_2 !== 4'd15) begin failures++; $display("FAIL fill_full_ptrs got=(%0d,%0d) exp=(15,15)", imm_ptr_1, imm_ptr_2); end
  endtask

  // Full buffer, release entry 5, then pair vs single requests.
  task automatic test_release_single();
    idle();
    issued_1 = 1; issue_imm_ptr_1 = 4'd5;
    next();
    idle();
    #1;
    checks++; if (imm_ptr_1 !== 4'd5 || free_cnt !== 5'd1) begin failures++; $display("FAIL rel_reoffer got ptr1=%0d cnt=%0d exp ptr1=5 cnt=1", imm_ptr_1, free_cnt); end
    req_1 = 1; req_2 = 1;
    #1;
    checks++; if (allocatable !== 1'b0 || invalid1 !== 1'b1 || invalid2 !== 1'b1) begin failures++; $display("FAIL rel_pair_block got alloc=%0b inv=(%0b,%0b) exp alloc=0 inv=(1,1)", allocatable, invalid1, invalid2); end
    next();
    checks++; if (free_cnt !== 5'd1) begin failures++; $display("FAIL rel_pair_nochange got cnt=%0d exp=1", free_cnt); end
    req_2 = 0;
    #1;
    checks++; if (allocatable !== 1'b1 || invalid1 !== 1'b0 || invalid2 !== 1'b1) begin failures++; $display("FAIL rel_single_go got alloc=%0b inv=(%0b,%0b) exp alloc=1 inv=(0,1)", allocatable, invalid1, invalid2); end
    next();
    idle();
    #1;
    checks++; if (free_cnt !== 5'd0) begin failures++; $display("FAIL rel_single_taken got cnt=%0d exp=0", free_cnt); end
  endtask

  // Stall blocks allocation but issue releases still land.
  task automatic test_stall();
    idle();
    issued_1 = 1; issue_imm_ptr_1 = 4'd7;
    issued_2 = 1; issue_imm_ptr_2 = 4'd9;
    next();
    idle();
    stall = 1; req_1 = 1; req_2 = 1;
    issued_2 = 1; issue_imm_ptr_2 = 4'd3;
    #1;
    checks++; if (invalid1 !== 1'b1 || invalid2 !== 1'b1) begin failures++; $display("FAIL stall_invalid got=(%0b,%0b) exp=(1,1)", invalid1, invalid2); end
    checks++; if (free_cnt !== 5'd2 || imm_ptr_1 !== 4'd7 || imm_ptr_2 !== 4'd9) begin failures++; $display("FAIL stall_pre got cnt=%0d ptr=(%0d,%0d) exp cnt=2 ptr=(7,9)", free_cnt, imm_ptr_1, imm_ptr_2); end
    next();
    idle();
    #1;
    checks++; if (free_cnt !== 5'd3 || imm_ptr_1 !== 4'd3 || imm_ptr_2 !== 4'd7) begin failures++; $display("FAIL stall_post got cnt=%0d ptr=(%0d,%0d) exp cnt=3 ptr=(3,7)", free_cnt, imm_ptr_1, imm_ptr_2); end
  endtask

  // Allocate, free on the next cycle, and see the entry re-offered one edge later.
  task automatic test_back_to_back();
    do_reset();
    req_1 = 1;
    next();
    idle();
    issued_1 = 1; issue_imm_ptr_1 = 4'd0; req_1 = 1;
    #1;
    checks++; if (imm_ptr_1 !== 4'd1 || invalid1 !== 1'b0) begin failures++; $display("FAIL b2b_busy got ptr1=%0d inv1=%0b exp ptr1=1 inv1=0", imm_ptr_1, invalid1); end
    next();
    idle();
    #1;
    checks++; if (imm_ptr_1 !== 4'd0 || imm_ptr_2 !== 4'd2 || free_cnt !== 5'd15) begin failures++; $display("FAIL b2b_reoffer got ptr=(%0d,%0d) cnt=%0d exp ptr=(0,2) cnt=15", imm_ptr_1, imm_ptr_2, free_cnt); end
  endtask

  // Reset asserted while requests are active wins and clears everything.
  task automatic test_reset_mid();
    req_1 = 1; req_2 = 1;
    next();
    reset = 1;
    next();
    reset = 0; idle();
    #1;
    checks++; if (free_cnt !== 5'd16 || imm_ptr_1 !== 4'd0 || imm_ptr_2 !== 4'd1) begin failures++; $display("FAIL reset_mid got cnt=%0d ptr=(%0d,%0d) exp cnt=16 ptr=(0,1)", free_cnt, imm_ptr_1, imm_ptr_2); end
  endtask

  // Entries 0-3 depend on branch bit1, entries 4-5 on bit0.
  task automatic tagged_fill();
    do_reset();
    req_1 = 1; req_2 = 1; spectag_1 = 5'b00010; spectag_2 = 5'b00010;
    next();
    next();
    spectag_1 = 5'b00001; spectag_2 = 5'b00001;
    next();
    idle();
  endtask

  task automatic test_recovery();
    logic [4:0] exp_cnt;
    tagged_fill();
    #1;
    checks++; if (free_cnt !== 5'd10) begin failures++; $display("FAIL rec_setup got cnt=%0d exp=10", free_cnt); end
    prmiss = 1; prtag = 5'b00010; req_1 = 1;
    #1;
    checks++; if (invalid1 !== 1'b1) begin failures++; $display("FAIL rec_miss_block got inv1=%0b exp=1", invalid1); end
    next();
    idle();
    #1;
`ifdef IMM_ALLOC_RECOVERY_EN
    checks++; if (free_cnt !== 5'd14 || imm_ptr_1 !== 4'd0) begin failures++; $display("FAIL rec_flush got cnt=%0d ptr1=%0d exp cnt=14 ptr1=0", free_cnt, imm_ptr_1); end
`else
    checks++; if (free_cnt !== 5'd10 || imm_ptr_1 !== 4'd6) begin failures++; $display("FAIL rec_noflush got cnt=%0d ptr1=%0d exp cnt=10 ptr1=6", free_cnt, imm_ptr_1); end
`endif
    req_1 = 1;
    #1;
    checks++; if (invalid1 !== 1'b0) begin failures++; $display("FAIL rec_after_miss got inv1=%0b exp=0", invalid1); end
    next();
    idle();

    // Resolving the branch first means a later mispredict on that tag frees nothing.
    tagged_fill();
    prsuccess = 1; prtag = 5'b00010;
    next();
    idle();
    prmiss = 1; prtag = 5'b00010;
    next();
    idle();
    #1;
    exp_cnt = 5'd10;
    checks++; if (free_cnt !== exp_cnt) begin failures++; $display("FAIL rec_success_keep got cnt=%0d exp=%0d", free_cnt, exp_cnt); end
  endtask

  initial begin
    reset = 1;
    idle();
    test_reset();
    test_fill();
    test_release_single();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_recovery();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
